// File: rtl/spm_pkg.sv
// Shared constants and state encoding for the SPM operand sequencer and its timer.
package spm_pkg;

    localparam int DATA_W           = 32;
    localparam int FLOAT_EXP_MSB    = 30;
    localparam int FLOAT_EXP_LSB    = 23;
    localparam int WORDS_PER_NEURON = 4;

    localparam int F_A1 = 0;
    localparam int F_W1 = 1;
    localparam int F_B1 = 2;
    localparam int F_W2 = 3;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // All-ones exponent marks NaN or +/-Inf.
    function automatic logic is_nan_inf(input logic [DATA_W-1:0] f);
        return &f[FLOAT_EXP_MSB:FLOAT_EXP_LSB];
    endfunction

endpackage

// File: rtl/spm_latency_timer.sv
// Loadable down-counter: i_start loads COMPUTE_CYCLES, o_done pulses for the
// cycle whose closing edge is the COMPUTE_CYCLES-th edge after the start edge.
module spm_latency_timer #(
    parameter int COMPUTE_CYCLES = 24
) (
    input  logic clk,
    input  logic areset,
    input  logic i_start,
    output logic o_done
);

    localparam int CNT_W = $clog2(COMPUTE_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!areset) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= CNT_W'(COMPUTE_CYCLES);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/spm_operand_sequencer.sv
// Streams 4*NUM_NEURONS float operands into a shadow set, commits them atomically to the
// SPM inputs, waits the compute latency and returns the result. Option: SPM_SEQ_NAN_FLAG_EN.
module spm_operand_sequencer
    import spm_pkg::*;
#(
    parameter int NUM_NEURONS    = 3,
    parameter int DATA_W         = spm_pkg::DATA_W,
    parameter int COMPUTE_CYCLES = 24
) (
    input  logic                          clk,
    input  logic                          areset,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_W-1:0]             s_data,
    output logic [NUM_NEURONS*DATA_W-1:0] o_a1,
    output logic [NUM_NEURONS*DATA_W-1:0] o_w1,
    output logic [NUM_NEURONS*DATA_W-1:0] o_b1,
    output logic [NUM_NEURONS*DATA_W-1:0] o_w2,
    input  logic [DATA_W-1:0]             i_result,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_W-1:0]             m_result,
`ifdef SPM_SEQ_NAN_FLAG_EN
    output logic                          o_nan_inf,
`endif
    output logic                          busy
);

    localparam int NUM_WORDS = WORDS_PER_NEURON * NUM_NEURONS;
    localparam int CNT_W     = $clog2(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    seq_state_t r_state;
    seq_state_t w_state_next;

    logic [CNT_W-1:0]                  r_word_cnt;
    logic                              r_s_ready;
    logic                              r_m_valid;
    logic [DATA_W-1:0]                 r_m_result;
    logic [NUM_WORDS-2:0][DATA_W-1:0]  r_shadow;
    logic [NUM_WORDS-1:0][DATA_W-1:0]  r_ops;
    logic [NUM_WORDS-1:0][DATA_W-1:0]  w_set;

    logic w_accept;
    logic w_commit;
    logic w_timer_done;
    logic w_capture;
    logic w_result_taken;

    assign w_accept       = s_valid && r_s_ready;
    assign w_commit       = w_accept && (r_word_cnt == LAST_IDX);
    assign w_capture      = (r_state == ST_WAIT) && w_timer_done;
    assign w_result_taken = r_m_valid && m_ready;

    spm_latency_timer #(
        .COMPUTE_CYCLES (COMPUTE_CYCLES)
    ) u_timer (
        .clk     (clk),
        .areset  (areset),
        .i_start (w_commit),
        .o_done  (w_timer_done)
    );

    // The final word bypasses the shadow so the whole set lands on the commit edge.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_set
            if (gi == NUM_WORDS - 1) begin : g_last
                assign w_set[gi] = s_data;
            end else begin : g_shadow
                assign w_set[gi] = r_shadow[gi];
            end
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_LOAD: if (w_commit)       w_state_next = ST_WAIT;
            ST_WAIT: if (w_timer_done)   w_state_next = ST_DONE;
            ST_DONE: if (w_result_taken) w_state_next = ST_LOAD;
            default:                     w_state_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!areset) begin
            r_state    <= ST_LOAD;
            r_word_cnt <= '0;
            r_s_ready  <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_s_ready  <= (w_state_next == ST_LOAD);
            if (w_commit) begin
                r_word_cnt <= '0;
            end else if (w_accept) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!areset) begin
            r_shadow <= '0;
        end else begin
            for (int k = 0; k < NUM_WORDS - 1; k++) begin
                if (w_accept && (r_word_cnt == CNT_W'(k))) begin
                    r_shadow[k] <= s_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!areset) begin
            r_ops <= '0;
        end else if (w_commit) begin
            r_ops <= w_set;
        end
    end

    always_ff @(posedge clk) begin
        if (!areset) begin
            r_m_valid  <= 1'b0;
            r_m_result <= '0;
        end else if (w_capture) begin
            r_m_valid  <= 1'b1;
            r_m_result <= i_result;
        end else if (w_result_taken) begin
            r_m_valid  <= 1'b0;
        end
    end

`ifdef SPM_SEQ_NAN_FLAG_EN
    logic r_nan_inf;

    always_ff @(posedge clk) begin
        if (!areset) begin
            r_nan_inf <= 1'b0;
        end else if (w_capture) begin
            r_nan_inf <= is_nan_inf(i_result);
        end else if (w_result_taken) begin
            r_nan_inf <= 1'b0;
        end
    end

    assign o_nan_inf = r_nan_inf;
`endif

    // Word k of a set belongs to neuron k/4, field k%4.
    generate
        for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_neuron
            assign o_a1[gi*DATA_W +: DATA_W] = r_ops[gi*WORDS_PER_NEURON + F_A1];
            assign o_w1[gi*DATA_W +: DATA_W] = r_ops[gi*WORDS_PER_NEURON + F_W1];
            assign o_b1[gi*DATA_W +: DATA_W] = r_ops[gi*WORDS_PER_NEURON + F_B1];
            assign o_w2[gi*DATA_W +: DATA_W] = r_ops[gi*WORDS_PER_NEURON + F_W2];
        end
    endgenerate

    assign s_ready  = r_s_ready;
    assign m_valid  = r_m_valid;
    assign m_result = r_m_result;
    assign busy     = (r_state != ST_LOAD);

endmodule
